regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Owns the single write port (A3/WD/WE) of the 32x32 register file.
- Shares the port between two sources: the in-order pipeline writeback stage and a long-latency unit (multiply/divide, LU) that returns results out of order.
- Buffers LU results in a small FIFO when the port is busy.
- Keeps a per-register scoreboard of LU-pending destinations and raises a decode-stage stall for RAW hazards against them.

Parameters:
- DEPTH, 4, LU result FIFO entries (power of 2, >=2)
- AW, 5, register address width
- DW, 32, data width

Ports:
- clk  in  1  clock; all state updates on posedge (the register file writes on negedge of the same cycle)
- rst  in  1  reset, asynchronous, active-low
- wb_we  in  1  pipeline writeback valid; always accepted, no backpressure
- wb_addr  in  AW  pipeline destination register
- wb_data  in  DW  pipeline write data
- lu_issue  in  1  LU operation issued this cycle
- lu_issue_addr  in  AW  destination of the issued LU op
- lu_valid  in  1  LU result valid
- lu_addr  in  AW  LU result destination
- lu_data  in  DW  LU result data
- lu_ready  out  1  arbiter accepts an LU result this cycle
- chk_a1  in  AW  decode source register 1
- chk_a2  in  AW  decode source register 2
- stall  out  1  RAW hazard against a pending LU destination
- busy  out  32  scoreboard vector
- rf_we  out  1  to register file WE
- rf_a3  out  AW  to register file A3
- rf_wd  out  DW  to register file WD

Behaviour:
- Reset (rst=0, async): FIFO empty, pointers and count cleared, busy=0. Outputs rf_we=0, rf_a3=0, rf_wd=0, lu_ready=1, stall=0.
- Port selection is combinational each cycle, at most one write. Priority order:
  1) Pipeline: wb_we=1 selects the pipeline.
  2) FIFO head: selected if the pipeline is not writing and the FIFO is not empty.
  3) LU bypass: selected if the pipeline is not writing, the FIFO is empty, and lu_valid=1. The result goes straight to the port and is not enqueued.
- rf_we is 0 whenever the selected address is 0; the register $0 write is dropped. A dropped write still counts as consumed (FIFO pops, lu handshake completes).
- LU handshake:
  - A transfer occurs when lu_valid && lu_ready. lu_ready = !full.
  - A transferred result is enqueued at posedge unless it took the bypass path.
  - When full and the head drains this cycle, lu_ready stays 0; no same-cycle refill.
- FIFO:
  - Pointers wrap modulo DEPTH. The count tracks occupancy.
  - Simultaneous push and pop leaves the count unchanged.
  - Order is preserved; an LU result never overtakes an earlier LU result.
- Scoreboard:
  - lu_issue with lu_issue_addr!=0 sets busy[addr] at posedge.
  - An LU result clears busy[addr] at the posedge of the cycle in which it is actually written to the port (bypass or FIFO head).
  - Same address set and cleared in one cycle: set wins.
  - busy[0] is always 0.
  - Pipeline writes never modify busy.
- stall = (chk_a1!=0 && busy[chk_a1]) || (chk_a2!=0 && busy[chk_a2]). Combinational, no latency.
- Issuing to an already-busy register is an upstream protocol error. Decode must stall on its destination as well. The arbiter does not track multiplicity.
- Latency: the pipeline write lands at negedge of the same cycle. An LU result lands in the same cycle if the port is free and the FIFO is empty; otherwise it drains one entry per pipeline-idle cycle.
- Reset mid-operation discards FIFO contents and busy bits immediately.

Decomposition:
- Shared package holds:
  - constants REG_ZERO=5'd0, NUM_REGS=32
  - typedef for the FIFO entry struct {addr, data}
  - the source-select encoding SRC_NONE/SRC_WB/SRC_FIFO/SRC_BYP
- One natural sub-module: regfile_wb_fifo, a synchronous DEPTH-entry FIFO with full/empty/count and async active-low reset.

Test Plan:
- Reset mid-run with 2 FIFO entries and busy[5]=1 -> rst low: rf_we=0, busy=0, lu_ready=1; after release the FIFO is empty and no stale writes occur.
- Idle pipeline, lu_issue to r7, then lu_valid r7=0xDEADBEEF two cycles later -> same cycle: rf_we=1, rf_a3=7, rf_wd=0xDEADBEEF; busy[7] clears next posedge; stall with chk_a1=7 is 1 before and 0 after.
- wb_we=1 every cycle for 6 cycles while the LU returns r1..r4 back-to-back -> FIFO fills to 4, lu_ready=0 on the 5th result. When wb_we drops, r1,r2,r3,r4 are written in order over 4 cycles.
- wb_we=1 to r3 and lu_valid to r9 in the same cycle, FIFO empty -> r3 written, r9 enqueued (count=1), written the next idle cycle.
- LU result to r0 and wb_we to r0 -> rf_we=0 both times; the LU handshake completes and the FIFO pops; busy[0] stays 0; chk_a1=0 never stalls.
- lu_issue r12 in the same cycle as the previous r12 result is written -> busy[12]=1 afterwards (set wins); stall remains until the second r12 result is written.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter_pkg
// Purpose  : Shared constants and types for the register-file write arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_wb_arbiter_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         NUM_REGS = 32;

  // One buffered long-latency result: destination register and value.
  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } lu_entry_t;

  // Which source owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_WB   = 2'd1,
    SRC_FIFO = 2'd2,
    SRC_BYP  = 2'd3
  } src_sel_t;

endpackage
`default_nettype wire

// File: rtl/regfile_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_fifo
// Purpose  : DEPTH-entry synchronous FIFO holding LU results that could not
//            reach the write port immediately. Async active-low reset.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_PTR_W = $clog2(DEPTH);

  logic [W-1:0]       r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;
  logic               w_push;
  logic               w_pop;

  assign full   = (r_count == (c_PTR_W+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign rdata  = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Owns the register-file write port, arbitrating between the
//            pipeline writeback and out-of-order LU results, with a result
//            FIFO and a scoreboard of LU-pending destinations for RAW stalls.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_we,
  input  logic [AW-1:0]       wb_addr,
  input  logic [DW-1:0]       wb_data,
  input  logic                lu_issue,
  input  logic [AW-1:0]       lu_issue_addr,
  input  logic                lu_valid,
  input  logic [AW-1:0]       lu_addr,
  input  logic [DW-1:0]       lu_data,
  output logic                lu_ready,
  input  logic [AW-1:0]       chk_a1,
  input  logic [AW-1:0]       chk_a2,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy,
  output logic                rf_we,
  output logic [AW-1:0]       rf_a3,
  output logic [DW-1:0]       rf_wd
);

  localparam logic [AW-1:0] c_ZERO = AW'(REG_ZERO);

  src_sel_t               w_src;
  logic [AW-1:0]          w_sel_addr;
  logic [DW-1:0]          w_sel_data;
  logic [AW+DW-1:0]       w_head;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [$clog2(DEPTH):0] w_fifo_count;
  logic                   w_unused_count;
  logic                   w_lu_xfer;
  logic                   w_push;
  logic                   w_pop;
  logic [NUM_REGS-1:0]    w_set_mask;
  logic [NUM_REGS-1:0]    w_clr_mask;
  logic [NUM_REGS-1:0]    r_busy;

  // Occupancy is only observed through full/empty here.
  assign w_unused_count = ^w_fifo_count;

  // A full FIFO refuses new results even while its head drains this cycle.
  assign lu_ready  = !w_fifo_full;
  assign w_lu_xfer = lu_valid && lu_ready;
  assign w_push    = w_lu_xfer && (w_src != SRC_BYP);
  assign w_pop     = (w_src == SRC_FIFO);

  regfile_wb_fifo #(
    .DEPTH (DEPTH),
    .W     (AW + DW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .wdata ({lu_addr, lu_data}),
    .rdata (w_head),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (w_fifo_count)
  );

  // Fixed priority: pipeline, then oldest buffered LU result, then LU bypass.
  always_comb begin
    w_src = SRC_NONE;
    if (!rst)               w_src = SRC_NONE;
    else if (wb_we)         w_src = SRC_WB;
    else if (!w_fifo_empty) w_src = SRC_FIFO;
    else if (lu_valid)      w_src = SRC_BYP;
  end

  // Route the chosen source onto the write port.
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    case (w_src)
      SRC_WB:   begin w_sel_addr = wb_addr;            w_sel_data = wb_data;         end
      SRC_FIFO: begin w_sel_addr = w_head[AW+DW-1:DW]; w_sel_data = w_head[DW-1:0];  end
      SRC_BYP:  begin w_sel_addr = lu_addr;            w_sel_data = lu_data;         end
      default:  begin w_sel_addr = '0;                 w_sel_data = '0;              end
    endcase
  end

  // Writes to $0 are consumed but never reach the register file.
  assign rf_we = (w_src != SRC_NONE) && (w_sel_addr != c_ZERO);
  assign rf_a3 = w_sel_addr;
  assign rf_wd = w_sel_data;

  assign w_set_mask = (lu_issue && (lu_issue_addr != c_ZERO))
                    ? (NUM_REGS'(1) << lu_issue_addr) : '0;
  assign w_clr_mask = ((w_src == SRC_FIFO) || (w_src == SRC_BYP))
                    ? (NUM_REGS'(1) << w_sel_addr) : '0;

  // Scoreboard: clear on LU write, set on issue (set wins), bit 0 pinned low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_busy <= '0;
    else      r_busy <= ((r_busy & ~w_clr_mask) | w_set_mask) & ~NUM_REGS'(1);
  end

  assign busy  = r_busy;
  assign stall = ((chk_a1 != c_ZERO) && r_busy[chk_a1]) ||
                 ((chk_a2 != c_ZERO) && r_busy[chk_a2]);

endmodule
`default_nettype wire
